// File: rtl/rx_pkg.sv
// Shared receive/transmit framing constants and the deframer state encoding.
package rx_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } rx_state_t;

  localparam int         RX_OSR         = 4;
  localparam logic [7:0] RX_SYNC_WORD   = 8'hA5;
  localparam int         RX_FRAME_BYTES = 4;

endpackage

// File: rtl/rx_bit_slicer.sv
// Symbol-timing phase counter and threshold slicer; bit/bit_valid are combinational
// from the current sample. No backpressure: a sample is consumed whenever sample_valid is high.
module rx_bit_slicer import rx_pkg::*; #(
  parameter int                 OSR          = RX_OSR,
  parameter int                 SAMPLE_PHASE = 2,
  parameter logic signed [15:0] THRESH       = 16'sd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid,
  output logic               sym_bit,
  output logic               bit_valid
);

  localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;

  logic [PW-1:0] phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= '0;
    end else if (sample_valid) begin
      phase <= (phase == PW'(OSR - 1)) ? '0 : phase + 1'b1;
    end
  end

  assign bit_valid = sample_valid && (phase == PW'(SAMPLE_PHASE));
  assign sym_bit   = (sample_in >= THRESH);

endmodule

// File: rtl/rx_slicer_deframer.sv
// Slices oversampled symbols, hunts for the sync word and assembles payload bytes.
// Byte appears 1 cycle after its deciding sample; if the held byte is not consumed, the new one is dropped and overflow pulses.
module rx_slicer_deframer import rx_pkg::*; #(
  parameter int                 OSR          = RX_OSR,
  parameter int                 SAMPLE_PHASE = 2,
  parameter logic signed [15:0] THRESH       = 16'sd0,
  parameter logic [7:0]         SYNC_WORD    = RX_SYNC_WORD,
  parameter int                 FRAME_BYTES  = RX_FRAME_BYTES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid,
  input  logic               out_ready,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  output logic               frame_active,
  output logic               overflow
);

  localparam logic [8:0] LAST_BYTE = 9'(FRAME_BYTES);

  logic       sym_bit;
  logic       bit_valid;

  rx_state_t  state, state_nxt;
  logic [7:0] sync_reg, sync_nxt;
  logic [7:0] shift_reg, shift_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] byte_cnt, byte_cnt_nxt;
  logic       byte_done;
  logic [7:0] done_byte;
  logic       load;
  logic       overflow_nxt;
  logic       byte_valid_nxt;
  logic [7:0] byte_out_nxt;

  rx_bit_slicer #(
    .OSR          (OSR),
    .SAMPLE_PHASE (SAMPLE_PHASE),
    .THRESH       (THRESH)
  ) u_slicer (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sym_bit      (sym_bit),
    .bit_valid    (bit_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      sync_reg   <= '0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      sync_reg   <= sync_nxt;
      shift_reg  <= shift_nxt;
      bit_cnt    <= bit_cnt_nxt;
      byte_cnt   <= byte_cnt_nxt;
      byte_out   <= byte_out_nxt;
      byte_valid <= byte_valid_nxt;
      overflow   <= overflow_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    sync_nxt     = sync_reg;
    shift_nxt    = shift_reg;
    bit_cnt_nxt  = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    byte_done    = 1'b0;
    done_byte    = '0;
    if (bit_valid) begin
      case (state)
        HUNT: begin
          sync_nxt = {sync_reg[6:0], sym_bit};
          if (sync_nxt == SYNC_WORD) begin
            state_nxt    = PAYLOAD;
            bit_cnt_nxt  = '0;
            byte_cnt_nxt = '0;
          end
        end
        PAYLOAD: begin
          shift_nxt = {shift_reg[6:0], sym_bit};
          if (bit_cnt == 3'd7) begin
            byte_done    = 1'b1;
            done_byte    = shift_nxt;
            bit_cnt_nxt  = '0;
            byte_cnt_nxt = byte_cnt + 8'd1;
            // Clearing the sync register forces a full fresh sync word for the next frame.
            if (({1'b0, byte_cnt} + 9'd1) == LAST_BYTE) begin
              state_nxt = HUNT;
              sync_nxt  = '0;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  assign load           = byte_done && (!byte_valid || out_ready);
  assign overflow_nxt   = byte_done && byte_valid && !out_ready;
  assign byte_out_nxt   = load ? done_byte : byte_out;
  assign byte_valid_nxt = load || (byte_valid && !out_ready);
  assign frame_active   = (state == PAYLOAD);

endmodule

// File: tb/tb_rx_slicer_deframer.sv
// Randomized and directed bench for rx_slicer_deframer against a bit-stream level model.
module tb_rx_slicer_deframer;

  localparam int         OSR  = 4;
  localparam int         SP   = 2;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         FB   = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic               out_ready = 1'b0;
  logic [7:0]         byte_out;
  logic               byte_valid;
  logic               frame_active;
  logic               overflow;

  always #5 clk = ~clk;

  rx_slicer_deframer #(
    .OSR          (OSR),
    .SAMPLE_PHASE (SP),
    .THRESH       (16'sd0),
    .SYNC_WORD    (SYNC),
    .FRAME_BYTES  (FB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .out_ready    (out_ready),
    .byte_out     (byte_out),
    .byte_valid   (byte_valid),
    .frame_active (frame_active),
    .overflow     (overflow)
  );

  int total = 0;
  int bad   = 0;

  // Model: valid samples since reset, last 8 hunted bits, payload bits still owed in this frame.
  int nsamp = 0;
  int hist = 0;
  int bits_left = 0;
  int acc = 0;
  bit m_valid = 0;
  int m_byte = 0;
  bit m_ovf = 0;
  int n_done = 0;
  int n_ovf = 0;
  int accepted[$];
  bit cmp_en = 0;
  int dut_ovf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input logic v, input logic signed [15:0] s, input logic r, input logic rst);
    bit done;
    int db;
    int b;
    done = 0;
    db   = 0;
    if (rst) begin
      nsamp = 0; hist = 0; bits_left = 0; acc = 0;
      m_valid = 0; m_byte = 0; m_ovf = 0;
    end else begin
      if (v) begin
        if ((nsamp % OSR) == SP) begin
          b = (int'(s) >= 0) ? 1 : 0;
          if (bits_left == 0) begin
            hist = ((hist << 1) | b) & 255;
            if (hist == int'(SYNC)) bits_left = FB * 8;
          end else begin
            acc = ((acc << 1) | b) & 255;
            bits_left--;
            if ((bits_left % 8) == 0) begin
              done = 1;
              db   = acc;
              n_done++;
              if (bits_left == 0) hist = 0;
            end
          end
        end
        nsamp++;
      end
      m_ovf = 0;
      if (done) begin
        if (!m_valid || r) begin
          if (m_valid) accepted.push_back(m_byte);
          m_byte  = db;
          m_valid = 1;
        end else begin
          m_ovf = 1;
          n_ovf++;
        end
      end else if (m_valid && r) begin
        accepted.push_back(m_byte);
        m_valid = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("byte_valid", 32'(byte_valid), 32'(m_valid));
      if (m_valid) chk("byte_out", 32'(byte_out), 32'(m_byte));
      chk("frame_active", 32'(frame_active), 32'(bits_left > 0));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (overflow === 1'b1) dut_ovf++;
    end
  end

  task automatic step(input logic v, input logic signed [15:0] s, input logic r, input logic rst);
    sample_valid = v;
    sample_in    = s;
    out_ready    = r;
    reset        = rst;
    @(posedge clk);
    model_update(v, s, r, rst);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 16'($urandom), 1'b1, 1'b1);
    step(1'b1, 16'($urandom), 1'b0, 1'b1);
    step(1'b0, 16'($urandom), 1'b0, 1'b0);
  endtask

  // style 0: all four samples at +/-1000; style 1: decision sample 0/-1, other phases of opposite sign.
  task automatic send_bit(input bit b, input int style, input logic r_oth, input logic r_dec);
    logic signed [15:0] val;
    for (int k = 0; k < OSR; k++) begin
      if ($urandom_range(4, 0) == 0) step(1'b0, 16'($urandom), r_oth, 1'b0);
      if (k == SP) begin
        if (style == 1) val = b ? 16'sd0 : -16'sd1;
        else            val = b ? 16'sd1000 : -16'sd1000;
        step(1'b1, val, r_dec, 1'b0);
      end else begin
        if (style == 1) val = b ? 16'(-int'($urandom_range(30000, 1))) : 16'($urandom_range(30000, 0));
        else            val = b ? 16'sd1000 : -16'sd1000;
        step(1'b1, val, r_oth, 1'b0);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input int style, input logic r_oth, input logic r_last_dec);
    for (int i = 7; i >= 0; i--) send_bit(d[i], style, r_oth, (i == 0) ? r_last_dec : r_oth);
  endtask

  initial begin
    int n0;
    int o0;
    int m0;
    logic [7:0] rb;

    do_reset();
    cmp_en = 1;
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_active", 32'(frame_active), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_byte", 32'(byte_out), 32'h00);

    // Sync then 3C held (ready low), rest of frame consumed.
    send_byte(8'hA5, 0, 1'b1, 1'b1);
    chk("sync_active", 32'(frame_active), 32'd1);
    send_byte(8'h3C, 0, 1'b0, 1'b0);
    chk("b1_valid", 32'(byte_valid), 32'd1);
    chk("b1_data", 32'(byte_out), 32'h3C);
    send_byte(8'h11, 0, 1'b1, 1'b1);
    send_byte(8'h22, 0, 1'b1, 1'b1);
    send_byte(8'h33, 0, 1'b1, 1'b1);
    chk("f1_inactive", 32'(frame_active), 32'd0);
    chk("f1_count", 32'(accepted.size()), 32'd4);
    chk("f1_first", 32'(accepted[0]), 32'h3C);

    // Full frame in order, then bytes without sync produce nothing.
    do_reset();
    accepted.delete();
    send_byte(8'hA5, 0, 1'b1, 1'b1);
    send_byte(8'h11, 0, 1'b1, 1'b1);
    send_byte(8'h22, 0, 1'b1, 1'b1);
    send_byte(8'h33, 0, 1'b1, 1'b1);
    send_byte(8'h44, 0, 1'b1, 1'b1);
    chk("f2_inactive", 32'(frame_active), 32'd0);
    chk("f2_count", 32'(accepted.size()), 32'd4);
    chk("f2_b0", 32'(accepted[0]), 32'h11);
    chk("f2_b3", 32'(accepted[3]), 32'h44);
    n0 = n_done;
    send_byte(8'h11, 0, 1'b1, 1'b1);
    chk("nosync_bytes", 32'(n_done - n0), 32'd0);
    chk("nosync_valid", 32'(byte_valid), 32'd0);

    // Stall over bytes 1-2: byte 2 dropped with one overflow pulse.
    do_reset();
    accepted.delete();
    o0 = dut_ovf;
    m0 = n_ovf;
    send_byte(8'hA5, 0, 1'b1, 1'b1);
    send_byte(8'h11, 0, 1'b0, 1'b0);
    send_byte(8'h22, 0, 1'b0, 1'b0);
    chk("stall_hold", 32'(byte_out), 32'h11);
    chk("stall_ovf_dut", 32'(dut_ovf - o0), 32'd1);
    chk("stall_ovf_model", 32'(n_ovf - m0), 32'd1);
    step(1'b0, 16'sd0, 1'b1, 1'b0);
    chk("stall_fall", 32'(byte_valid), 32'd0);
    chk("stall_acc", 32'(accepted[0]), 32'h11);
    send_byte(8'h33, 0, 1'b1, 1'b1);
    send_byte(8'h44, 0, 1'b1, 1'b1);

    // Accept coinciding with the next completion: reload, no overflow.
    do_reset();
    accepted.delete();
    o0 = dut_ovf;
    send_byte(8'hA5, 0, 1'b1, 1'b1);
    send_byte(8'h11, 0, 1'b0, 1'b0);
    send_byte(8'h22, 0, 1'b0, 1'b1);
    chk("b2b_valid", 32'(byte_valid), 32'd1);
    chk("b2b_data", 32'(byte_out), 32'h22);
    send_byte(8'h33, 0, 1'b0, 1'b1);
    send_byte(8'h44, 0, 1'b0, 1'b1);
    step(1'b0, 16'sd0, 1'b1, 1'b0);
    chk("b2b_no_ovf", 32'(dut_ovf - o0), 32'd0);
    chk("b2b_count", 32'(accepted.size()), 32'd4);
    chk("b2b_last", 32'(accepted[3]), 32'h44);

    // Threshold boundary: 0 decides 1, -1 decides 0, off-phase samples ignored.
    do_reset();
    send_byte(8'hA5, 1, 1'b1, 1'b1);
    send_byte(8'hF0, 1, 1'b0, 1'b0);
    chk("thr_data", 32'(byte_out), 32'hF0);
    chk("thr_valid", 32'(byte_valid), 32'd1);
    send_byte(8'h0F, 1, 1'b1, 1'b1);
    send_byte(8'h81, 1, 1'b1, 1'b1);
    send_byte(8'h7E, 1, 1'b1, 1'b1);

    // Reset after 3 payload bits; stream resumes without sync.
    do_reset();
    send_byte(8'hA5, 0, 1'b1, 1'b1);
    send_bit(1'b1, 0, 1'b1, 1'b1);
    send_bit(1'b0, 0, 1'b1, 1'b1);
    send_bit(1'b1, 0, 1'b1, 1'b1);
    chk("mid_active", 32'(frame_active), 32'd1);
    step(1'b1, 16'sd1000, 1'b1, 1'b1);
    chk("mid_rst_active", 32'(frame_active), 32'd0);
    chk("mid_rst_valid", 32'(byte_valid), 32'd0);
    chk("mid_rst_byte", 32'(byte_out), 32'h00);
    n0 = n_done;
    send_bit(1'b1, 0, 1'b1, 1'b1);
    send_bit(1'b0, 0, 1'b1, 1'b1);
    send_bit(1'b1, 0, 1'b1, 1'b1);
    send_bit(1'b1, 0, 1'b1, 1'b1);
    send_bit(1'b0, 0, 1'b1, 1'b1);
    send_byte(8'h3C, 0, 1'b1, 1'b1);
    send_byte(8'h11, 0, 1'b1, 1'b1);
    chk("mid_no_bytes", 32'(n_done - n0), 32'd0);
    send_byte(8'hA5, 0, 1'b1, 1'b1);
    for (int i = 0; i < FB; i++) send_byte(8'(8'h10 + i), 0, 1'b1, 1'b1);
    chk("mid_resync", 32'(n_done - n0), 32'(FB));

    // Random episodes: aligned frame with random readiness, then free-running noise.
    n0 = n_done;
    for (int ep = 0; ep < 10; ep++) begin
      do_reset();
      send_byte(8'hA5, ep % 2, 1'b1, 1'b1);
      for (int i = 0; i < FB; i++) begin
        rb = 8'($urandom);
        send_byte(rb, ep % 2, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      end
      for (int c = 0; c < 1500; c++) begin
        logic signed [15:0] sv;
        if ($urandom_range(1, 0) == 1) sv = ($urandom_range(1, 0) == 1) ? 16'sd1000 : -16'sd1000;
        else                           sv = 16'($urandom);
        step(1'($urandom_range(3, 0) != 0), sv, 1'($urandom_range(2, 0) != 0),
             1'($urandom_range(2999, 0) == 0));
      end
    end
    chk("rand_frames_seen", 32'(n_done - n0 >= 10 * FB), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
